// File: rtl/gate_selftest_checker.sv
// Built-in self-test checker for a 2-input logic gate: walks {A,B} through 00..11,
// samples the gate response at the end of each hold window and tallies mismatches.
module gate_selftest_checker #(
  parameter int unsigned HOLD_CYCLES = 100,
  parameter logic [3:0]  TRUTH       = 4'b0110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [HW-1:0] hold;

  logic       mismatch;
  logic [2:0] err_next;
  logic [3:0] fail_next;

  // Case inequality so an X/Z response is scored as a failure in simulation.
  always_comb begin
    mismatch  = (y_in !== TRUTH[idx]);
    err_next  = err_count + {2'b00, mismatch};
    fail_next = fail_vec;
    if (mismatch) fail_next[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      idx       <= 2'd0;
      hold      <= '0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_vec  <= 4'd0;
    end else begin
      case (state)
        StIdle, StDone: begin
          if (start) begin
            state     <= StRun;
            idx       <= 2'd0;
            hold      <= '0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
          end
        end
        StRun: begin
          if (hold == HOLD_LAST) begin
            hold      <= '0;
            err_count <= err_next;
            fail_vec  <= fail_next;
            if (idx != 2'd3) begin
              idx            <= idx + 2'd1;
              {a_out, b_out} <= idx + 2'd1;
            end else begin
              state <= StDone;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == 3'd0);
              a_out <= 1'b0;
              b_out <= 1'b0;
            end
          end else begin
            hold <= hold + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_selftest_checker.sv
// Self-checking bench for gate_selftest_checker with a short hold window and a
// selectable gate model driving y_in.
module tb_gate_selftest_checker;

  localparam int         H = 4;
  localparam logic [3:0] T = 4'b0110;

  logic       clk = 1'b0;
  logic       rst, start, y_in;
  logic       a_out, b_out, busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  int   mode;
  logic y_force;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [2:0] err;
    logic [3:0] fail;
    logic       pass;
  } res_t;
  res_t sb[$];

  gate_selftest_checker #(.HOLD_CYCLES(H), .TRUTH(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_out     (a_out),
    .b_out     (b_out),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  always #5 clk = ~clk;

  // 0: correct XOR, 1: stuck-at-0, 2: XNOR, 3: bench-driven value
  always_comb begin
    case (mode)
      0:       y_in = a_out ^ b_out;
      1:       y_in = 1'b0;
      2:       y_in = ~(a_out ^ b_out);
      default: y_in = y_force;
    endcase
  end

  task automatic check_idle(input string name);
    checks++;
    if ({a_out, b_out, busy, done, pass} !== 5'b0 || err_count !== 3'd0 || fail_vec !== 4'd0) begin
      errors++;
      $display("FAIL %s: ab=%b%b busy=%b done=%b pass=%b err=%0d fail=%b, want all 0",
               name, a_out, b_out, busy, done, pass, err_count, fail_vec);
    end
  endtask

  // Full run from the start edge; restart_at pulses start mid-run (-1 = never).
  task automatic run_check(input int m, input logic [2:0] e, input logic [3:0] f,
                           input int restart_at);
    res_t r;
    res_t got;
    mode   = m;
    r.err  = e;
    r.fail = f;
    r.pass = (e == 3'd0);
    sb.push_back(r);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 4 * H; c++) begin
      if (m == 3) y_force = ((c % H) == H - 1) ? T[c / H] : ~T[c / H];
      checks++;
      if ({a_out, b_out} !== 2'(c / H) || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL run_cycle%0d: ab=%b%b busy=%b done=%b, want ab=%0d busy=1 done=0",
                 c, a_out, b_out, busy, done, c / H);
      end
      if (c == 0) begin
        checks++;
        if (err_count !== 3'd0 || fail_vec !== 4'd0 || pass !== 1'b0) begin
          errors++;
          $display("FAIL start_clear: err=%0d fail=%b pass=%b, want 0 0000 0",
                   err_count, fail_vec, pass);
        end
      end
      if (c == restart_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || {a_out, b_out} !== 2'b00) begin
      errors++;
      $display("FAIL done_edge: done=%b busy=%b ab=%b%b, want done=1 busy=0 ab=00",
               done, busy, a_out, b_out);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: queue empty at done, want 1 entry");
    end else begin
      got = sb.pop_front();
      if (err_count !== got.err || fail_vec !== got.fail || pass !== got.pass) begin
        errors++;
        $display("FAIL result: err=%0d fail=%b pass=%b, want err=%0d fail=%b pass=%b",
                 err_count, fail_vec, pass, got.err, got.fail, got.pass);
      end
    end
    // Results must hold while idling in DONE.
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || err_count !== e || fail_vec !== f) begin
      errors++;
      $display("FAIL done_hold: done=%b err=%0d fail=%b, want 1 %0d %b",
               done, err_count, fail_vec, e, f);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    check_idle("reset_with_start");
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    check_idle("reset_stays_idle");
  endtask

  task automatic test_xor_pass();
    run_check(0, 3'd0, 4'b0000, -1);
  endtask

  task automatic test_stuck0();
    run_check(1, 3'd2, 4'b0110, -1);
  endtask

  task automatic test_xnor();
    run_check(2, 3'd4, 4'b1111, -1);
  endtask

  task automatic test_glitch();
    run_check(3, 3'd0, 4'b0000, -1);
  endtask

  task automatic test_start_ignored();
    run_check(0, 3'd0, 4'b0000, 5);
  endtask

  task automatic test_reset_midrun();
    mode  = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle("midrun_reset");
    @(posedge clk); #1;
    check_idle("midrun_reset_idle");
    run_check(0, 3'd0, 4'b0000, -1);
  endtask

  task automatic test_back_to_back();
    run_check(1, 3'd2, 4'b0110, -1);
    run_check(0, 3'd0, 4'b0000, -1);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    mode    = 0;
    y_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_xor_pass();
    test_stuck0();
    test_xnor();
    test_glitch();
    test_start_ignored();
    test_reset_midrun();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
